// File: rtl/uart_frame_receiver.sv
// Collects one framed packet (HDR0 HDR1 payload [checksum]) from the UART RX byte strobe.
// Optional trailing checksum byte is enabled by defining FRAME_RX_CHECKSUM_EN.
module uart_frame_receiver #(
    parameter logic [7:0] HDR0           = 8'hAB,
    parameter logic [7:0] HDR1           = 8'h41,
    parameter int         PAYLOAD_BYTES  = 3136,
    parameter int         TIMEOUT_CYCLES = 0,
    parameter int         CNT_W          = 32
) (
    input  logic                       i_clk_sys,
    input  logic                       i_rst,
    input  logic [7:0]                 i_rx_byte,
    input  logic                       i_rx_done,
    output logic [PAYLOAD_BYTES*8-1:0] o_payload,
    output logic                       o_frame_done,
    output logic                       o_frame_err,
    output logic [1:0]                 o_err_code,
    output logic                       o_busy
);

    localparam int PW = PAYLOAD_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
`ifdef FRAME_RX_CHECKSUM_EN
        , ST_CKSUM = 2'd3
`endif
    } state_t;

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        sum8 = a + b;
    endfunction

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_idle, w_idle_next;
    logic [PW-1:0]    r_shadow, w_shadow_next;
    logic [PW-1:0]    r_payload;
    logic             r_frame_done, r_frame_err, r_busy;
    logic [1:0]       r_err_code;
    logic             w_load, w_done, w_err, w_timeout;
    logic [1:0]       w_code;
    logic [PW-1:0]    w_shifted;
`ifdef FRAME_RX_CHECKSUM_EN
    logic [7:0]       r_sum, w_sum_next;
`endif

    assign w_shifted = (r_shadow << 8) | {{(PW-8){1'b0}}, i_rx_byte};

    // State register
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, datapath updates and output events
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_shadow_next = r_shadow;
        w_load        = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_code        = r_err_code;
        w_timeout     = 1'b0;
`ifdef FRAME_RX_CHECKSUM_EN
        w_sum_next    = r_sum;
`endif
        // A byte arriving on the would-be timeout cycle wins over the timeout
        if ((TIMEOUT_CYCLES > 0) && (r_state != ST_IDLE) && !i_rx_done &&
            ((r_idle + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES))) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
        if ((r_state == ST_IDLE) || i_rx_done || (TIMEOUT_CYCLES == 0)) begin
            w_idle_next = '0;
        end else begin
            w_idle_next = r_idle + CNT_W'(1);
        end
        if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_err        = 1'b1;
            w_code       = 2'b01;
            w_idle_next  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_next = '0;
`ifdef FRAME_RX_CHECKSUM_EN
                    w_sum_next = 8'h00;
`endif
                    if (i_rx_done && (i_rx_byte == HDR0)) begin
                        w_state_next = ST_HDR;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (!i_rx_done) begin
                        w_state_next = ST_HDR;
                    end else if (i_rx_byte == HDR1) begin
                        w_state_next = ST_PAYLOAD;
                    end else if (i_rx_byte == HDR0) begin
                        w_state_next = ST_HDR;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_rx_done) begin
                        w_shadow_next = w_shifted;
                        w_cnt_next    = r_cnt + CNT_W'(1);
`ifdef FRAME_RX_CHECKSUM_EN
                        w_sum_next    = sum8(r_sum, i_rx_byte);
                        if (w_cnt_next == CNT_W'(PAYLOAD_BYTES)) begin
                            w_state_next = ST_CKSUM;
                        end else begin
                            w_state_next = ST_PAYLOAD;
                        end
`else
                        if (w_cnt_next == CNT_W'(PAYLOAD_BYTES)) begin
                            w_state_next = ST_IDLE;
                            w_load       = 1'b1;
                            w_done       = 1'b1;
                        end else begin
                            w_state_next = ST_PAYLOAD;
                        end
`endif
                    end else begin
                        w_state_next = ST_PAYLOAD;
                    end
                end
`ifdef FRAME_RX_CHECKSUM_EN
                ST_CKSUM: begin
                    if (!i_rx_done) begin
                        w_state_next = ST_CKSUM;
                    end else if (i_rx_byte == r_sum) begin
                        w_state_next = ST_IDLE;
                        w_load       = 1'b1;
                        w_done       = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_err        = 1'b1;
                        w_code       = 2'b10;
                    end
                end
`endif
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_idle       <= '0;
            r_shadow     <= '0;
            r_payload    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= 2'b00;
            r_busy       <= 1'b0;
`ifdef FRAME_RX_CHECKSUM_EN
            r_sum        <= 8'h00;
`endif
        end else begin
            r_cnt        <= w_cnt_next;
            r_idle       <= w_idle_next;
            r_shadow     <= w_shadow_next;
            // Without checksum the final byte is still in flight, so load the shifted value
            r_payload    <= w_load ? w_shadow_next : r_payload;
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
            r_err_code   <= w_code;
            r_busy       <= (w_state_next != ST_IDLE);
`ifdef FRAME_RX_CHECKSUM_EN
            r_sum        <= w_sum_next;
`endif
        end
    end

    assign o_payload    = r_payload;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;
    assign o_err_code   = r_err_code;
    assign o_busy       = r_busy;

endmodule

// File: doc/uart_frame_receiver.md
# uart_frame_receiver

- Parametrised successor to the fixed-size UART image receiver: collects one framed packet of PAYLOAD_BYTES bytes from the UART RX byte strobe and presents it as one packed vector.
- New versus the fixed receiver:
  - configurable two-byte header with resynchronisation;
  - exact payload count;
  - inter-byte timeout;
  - payload output double-buffered, updated only on a good frame;
  - optional trailing checksum.
- Sits between the UART RX byte deserialiser and the CNN input buffer.

## Interface
- HDR0, 8'hAB, first header byte
- HDR1, 8'h41, second header byte
- PAYLOAD_BYTES, 3136, payload length in bytes (≥1)
- TIMEOUT_CYCLES, 0, max clocks between accepted bytes once a frame has started; 0 disables the timeout
- CNT_W, 32, width of byte counter and timeout counter
- i_clk_sys  input  1  system clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_rx_byte  input  8  received byte, valid when i_rx_done=1
- i_rx_done  input  1  one-cycle strobe per received byte
- o_payload  output  PAYLOAD_BYTES*8  last good frame; first payload byte in bits [PAYLOAD_BYTES*8-1 -: 8]
- o_frame_done  output  1  one-cycle pulse, o_payload updated this cycle
- o_frame_err  output  1  one-cycle pulse, frame discarded
- o_err_code  output  2  valid with o_frame_err: 2'b01 timeout, 2'b10 checksum mismatch; holds last value otherwise
- o_busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, HDR, PAYLOAD, CKSUM. CKSUM exists only with the checksum feature.
- IDLE:
  - i_rx_done with byte==HDR0 → HDR.
  - Any other byte is ignored.
  - Clears the byte counter.
- HDR, on i_rx_done:
  - byte==HDR1 → PAYLOAD;
  - byte==HDR0 → stay in HDR (resync, e.g. AB AB 41 is accepted);
  - any other byte → IDLE, no error pulse.
- PAYLOAD, on i_rx_done:
  - Shift the byte into an internal shadow register (shift-left, new byte in LSBs) and increment the counter.
  - On the byte where count reaches exactly PAYLOAD_BYTES, the frame completes. Exactly PAYLOAD_BYTES bytes are captured, no extra byte.
  - Without the checksum feature: copy shadow to o_payload (including the final byte), pulse o_frame_done, go to IDLE.
  - With the checksum feature: go to CKSUM.
- Running 8-bit sum: the payload bytes are summed mod 256, cleared when the state leaves IDLE.
- Timeout:
  - If TIMEOUT_CYCLES>0 and the state is HDR, PAYLOAD or CKSUM, an idle counter increments every clock without i_rx_done and clears on i_rx_done.
  - When it reaches TIMEOUT_CYCLES: pulse o_frame_err with o_err_code=01, go to IDLE, leave o_payload unchanged.
- Simultaneous events: i_rx_done in the same cycle the timeout would fire counts as a byte; no timeout that cycle.
- The shadow register is never visible at o_payload mid-frame.

## Timing
- All outputs are registered.
- o_frame_done / o_frame_err rise on the clock edge that samples the final i_rx_done (or the timeout), last exactly one cycle, and coincide with the o_payload update.
- Back-to-back frames: a header byte may arrive the cycle after o_frame_done; IDLE accepts it.
- Reset values: o_payload=0, o_frame_done=0, o_frame_err=0, o_err_code=0, o_busy=0, state IDLE, all counters 0, shadow 0.
- Reset mid-frame aborts with no pulse; o_payload returns to 0.
- Counter arithmetic: CNT_W bits, compared for equality only; CNT_W must hold PAYLOAD_BYTES and TIMEOUT_CYCLES.

## Configuration
- FRAME_RX_CHECKSUM_EN defined:
  - After the last payload byte, CKSUM waits for one more byte.
  - If it equals the running sum: update o_payload, pulse o_frame_done.
  - Otherwise: pulse o_frame_err with o_err_code=10, o_payload unchanged.
  - In both cases → IDLE.
  - Timeout applies in CKSUM.
- Not defined: the checksum adder and the CKSUM state are absent; o_err_code=10 never occurs.

## Test plan
- Parameters unless noted: PAYLOAD_BYTES=4, TIMEOUT_CYCLES=20.
- Good frame, no checksum: AB 41 11 22 33 44 → one o_frame_done pulse; o_payload=32'h11223344; o_busy falls with it.
- Resync and reject: AB AB 41 01 02 03 04 → o_payload=32'h01020304. Then AB 00 01 02 03 04 → no pulse; o_payload unchanged.
- Timeout: AB 41 55, then 20 idle clocks → o_frame_err with o_err_code=01; o_payload holds the previous value. Next full frame AB 41 A0 A1 A2 A3 → o_payload=32'hA0A1A2A3.
- Checksum (FRAME_RX_CHECKSUM_EN):
  - AB 41 01 02 03 04 0A → o_frame_done.
  - Same frame with trailer 0B → o_frame_err, o_err_code=10, o_payload unchanged.
  - Payload FF FF FF FF with trailer FC → o_frame_done (sum wraps mod 256).
- Reset mid-frame: assert i_rst after AB 41 11 22 → all outputs 0 next cycle. Then AB 41 11 22 33 44 → o_payload=32'h11223344.
- Back-to-back at full rate: two frames with no gap (i_rx_done every cycle) → two o_frame_done pulses, payloads correct, no error.
